// File: rtl/inference_accuracy_tracker_if.sv
// Result-pair handshake plus running-statistics readout between the inference pipeline and the accuracy tracker.
// The producer side holds a pair stable until res_valid && res_ready; per-class counters are read back through class_sel.
interface inference_accuracy_tracker_if #(
    parameter int NUM_CLASSES = 10,
    parameter int COUNT_W     = 8,
    parameter int ACC_W       = 9,
    parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
);
    logic                   res_valid;
    logic                   res_ready;
    logic [NUM_CLASSES-1:0] expected_output;
    logic [NUM_CLASSES-1:0] obtained_output;
    logic                   last_hit;
    logic [COUNT_W-1:0]     count;
    logic [COUNT_W-1:0]     correct;
    logic [ACC_W-1:0]       accuracy;
    logic                   acc_valid;
    logic                   complete;
    logic [CLS_W-1:0]       class_sel;
    logic [COUNT_W-1:0]     class_total;
    logic [COUNT_W-1:0]     class_hits;

    modport master (
        output res_valid, expected_output, obtained_output, class_sel,
        input  res_ready, last_hit, count, correct, accuracy, acc_valid,
               complete, class_total, class_hits
    );

    modport slave (
        input  res_valid, expected_output, obtained_output, class_sel,
        output res_ready, last_hit, count, correct, accuracy, acc_valid,
               complete, class_total, class_hits
    );
endinterface

// File: rtl/inference_accuracy_tracker.sv
// Running accuracy scoreboard: counts samples, hits and per-class totals, then derives floor(correct*100/count)
// with a 7-step restoring divider; one sample per 8 cycles, res_ready low while dividing or once the run is complete.
module inference_accuracy_tracker #(
    parameter int NUM_CLASSES = 10,
    parameter int MAX_INPUTS  = 200,
    parameter int COUNT_W     = $clog2(MAX_INPUTS + 1),
    parameter int ACC_W       = 9,
    parameter int MATCH_MODE  = 0
) (
    input  logic clk,
    input  logic rst_overall,
    input  logic rst_vals,
    inference_accuracy_tracker_if.slave bus
);
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int REM_W = COUNT_W + 7;

    typedef enum logic {IDLE, DIV} state_t;

    state_t state_q, state_d;

    logic               done_q;
    logic [COUNT_W-1:0] count_r, correct_r;
    logic               last_hit_r;
    logic [ACC_W-1:0]   accuracy_r;
    logic               acc_valid_r;
    logic [REM_W-1:0]   rem_q;
    logic [6:0]         q_q;
    logic [2:0]         idx_q;
    logic [COUNT_W-1:0] class_total_r [NUM_CLASSES];
    logic [COUNT_W-1:0] class_hits_r  [NUM_CLASSES];

    logic               res_ready;
    logic               accept;
    logic               div_last;
    logic               hit;
    logic               label_vld;
    logic [CLS_W-1:0]   label_cls;
    logic [COUNT_W-1:0] count_new, correct_new;
    logic [REM_W-1:0]   cw, times100;
    logic [REM_W-1:0]   divisor, rem_step;
    logic [6:0]         q_step;
    logic               ge;
    logic               sel_in_range;

    assign res_ready = (state_q == IDLE) && !done_q;

    always_ff @(posedge clk or posedge rst_overall) begin
        if (rst_overall) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        div_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.res_valid && res_ready) begin
                    accept  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (idx_q == 3'd0) begin
                    div_last = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Clearing beats everything, including a sample offered in the same cycle.
        if (rst_vals) begin
            state_d  = IDLE;
            accept   = 1'b0;
            div_last = 1'b0;
        end
    end

    always_comb begin
        if (MATCH_MODE == 0) begin
            hit = (bus.obtained_output == bus.expected_output);
        end else begin
            hit = |(bus.obtained_output & bus.expected_output);
        end
        label_vld = |bus.expected_output;
        label_cls = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            if (bus.expected_output[i]) label_cls = CLS_W'(i);
        end
        count_new   = count_r + 1'b1;
        correct_new = correct_r + COUNT_W'(hit);
        cw          = REM_W'(correct_new);
        times100    = (cw << 6) + (cw << 5) + (cw << 2);
    end

    // Restoring step: correct <= count keeps the quotient below 128, so bits 6..0 cover it.
    always_comb begin
        divisor  = REM_W'(count_r) << idx_q;
        ge       = (rem_q >= divisor);
        rem_step = ge ? (rem_q - divisor) : rem_q;
        q_step   = ge ? (q_q | (7'd1 << idx_q)) : q_q;
    end

    always_ff @(posedge clk or posedge rst_overall) begin
        if (rst_overall) begin
            done_q      <= 1'b0;
            count_r     <= '0;
            correct_r   <= '0;
            last_hit_r  <= 1'b0;
            accuracy_r  <= '0;
            acc_valid_r <= 1'b0;
            rem_q       <= '0;
            q_q         <= '0;
            idx_q       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                class_total_r[i] <= '0;
                class_hits_r[i]  <= '0;
            end
        end else if (rst_vals) begin
            done_q      <= 1'b0;
            count_r     <= '0;
            correct_r   <= '0;
            last_hit_r  <= 1'b0;
            accuracy_r  <= '0;
            acc_valid_r <= 1'b0;
            rem_q       <= '0;
            q_q         <= '0;
            idx_q       <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                class_total_r[i] <= '0;
                class_hits_r[i]  <= '0;
            end
        end else begin
            acc_valid_r <= 1'b0;
            if (accept) begin
                count_r    <= count_new;
                correct_r  <= correct_new;
                last_hit_r <= hit;
                if (label_vld) begin
                    class_total_r[label_cls] <= class_total_r[label_cls] + 1'b1;
                    if (hit) class_hits_r[label_cls] <= class_hits_r[label_cls] + 1'b1;
                end
                rem_q <= times100;
                q_q   <= '0;
                idx_q <= 3'd6;
                if (count_new == COUNT_W'(MAX_INPUTS)) done_q <= 1'b1;
            end else if (state_q == DIV) begin
                rem_q <= rem_step;
                q_q   <= q_step;
                idx_q <= idx_q - 3'd1;
                if (div_last) begin
                    accuracy_r  <= ACC_W'(q_step);
                    acc_valid_r <= 1'b1;
                end
            end
        end
    end

    assign sel_in_range = ({1'b0, bus.class_sel} < (CLS_W + 1)'(NUM_CLASSES));

    assign bus.res_ready   = res_ready;
    assign bus.last_hit    = last_hit_r;
    assign bus.count       = count_r;
    assign bus.correct     = correct_r;
    assign bus.accuracy    = accuracy_r;
    assign bus.acc_valid   = acc_valid_r;
    assign bus.complete    = done_q && (state_q == IDLE);
    assign bus.class_total = sel_in_range ? class_total_r[bus.class_sel] : '0;
    assign bus.class_hits  = sel_in_range ? class_hits_r[bus.class_sel]  : '0;
endmodule
